// File: rtl/pit_irq_ctrl.sv
// Interrupt collector for the mini PIT: turns single-cycle expiry pulses into a
// maskable level interrupt with post-ack hold-off, a one-deep queue and status counters.
module pit_irq_ctrl #(
    parameter int HOLDOFF   = 4,
    parameter int OVF_WIDTH = 4,
    parameter int TOT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick_in,
    input  logic                 enable,
    input  logic                 mask,
    input  logic                 ack,
    input  logic                 clear_ovf,
    output logic                 irq_out,
    output logic                 pending,
    output logic                 queued,
    output logic [OVF_WIDTH-1:0] overrun_count,
    output logic                 overrun_sat,
    output logic [TOT_WIDTH-1:0] tick_total
);

    localparam int CW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [CW-1:0]        HOLD_LOAD = CW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
    localparam logic [OVF_WIDTH-1:0] OVF_MAX   = '1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          hold_cnt_q, hold_cnt_d;
    logic                   queued_q, queued_d;
    logic [OVF_WIDTH-1:0]   ovf_q, ovf_d;
    logic [TOT_WIDTH-1:0]   tot_q, tot_d;
    logic                   ovf_inc;

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        queued_d   = queued_q;
        tot_d      = tot_q;
        ovf_inc    = 1'b0;

        if (!enable) begin
            state_d    = ST_IDLE;
            queued_d   = 1'b0;
            hold_cnt_d = '0;
        end else begin
            if (tick_in) tot_d = tot_q + TOT_WIDTH'(1);
            case (state_q)
                ST_IDLE: begin
                    if (tick_in) state_d = ST_PENDING;
                end
                ST_PENDING: begin
                    if (ack) begin
                        if (HOLDOFF > 0) begin
                            // A tick arriving with the ack is parked in the queue, not lost.
                            state_d    = ST_HOLDOFF;
                            hold_cnt_d = HOLD_LOAD;
                            queued_d   = tick_in;
                        end else begin
                            state_d = tick_in ? ST_PENDING : ST_IDLE;
                        end
                    end else if (tick_in) begin
                        ovf_inc = 1'b1;
                    end
                end
                ST_HOLDOFF: begin
                    if (tick_in && queued_q) ovf_inc = 1'b1;
                    if (hold_cnt_q == '0) begin
                        state_d  = (queued_q || tick_in) ? ST_PENDING : ST_IDLE;
                        queued_d = 1'b0;
                    end else begin
                        hold_cnt_d = hold_cnt_q - CW'(1);
                        if (tick_in) queued_d = 1'b1;
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    queued_d   = 1'b0;
                    hold_cnt_d = '0;
                end
            endcase
        end

        // Clear wins over the old value but keeps a coincident overrun.
        ovf_d = ovf_q;
        if (clear_ovf) begin
            ovf_d = ovf_inc ? OVF_WIDTH'(1) : '0;
        end else if (ovf_inc && (ovf_q != OVF_MAX)) begin
            ovf_d = ovf_q + OVF_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
            queued_q   <= 1'b0;
            ovf_q      <= '0;
            tot_q      <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            queued_q   <= queued_d;
            ovf_q      <= ovf_d;
            tot_q      <= tot_d;
        end
    end

    assign pending       = (state_q == ST_PENDING);
    assign irq_out       = pending & ~mask;
    assign queued        = queued_q;
    assign overrun_count = ovf_q;
    assign overrun_sat   = (ovf_q == OVF_MAX);
    assign tick_total    = tot_q;

endmodule

// File: tb/tb_pit_irq_ctrl.sv
// Bench for pit_irq_ctrl: directed scenarios followed by random traffic, all
// checked every cycle against a behavioural model of the collector.
module tb_pit_irq_ctrl;

    localparam int HOLDOFF = 4;
    localparam int OVF_MAX = 15;
    localparam int TOT_MOD = 256;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick_in = 1'b0;
    logic       enable = 1'b0;
    logic       mask = 1'b0;
    logic       ack = 1'b0;
    logic       clear_ovf = 1'b0;
    logic       irq_out, pending, queued, overrun_sat;
    logic [3:0] overrun_count;
    logic [7:0] tick_total;

    int n_vec  = 0;
    int n_fail = 0;

    // Behavioural model: hold_left = cycles of hold-off still to run (0 = none).
    bit m_pend, m_q;
    int m_hold, m_ovf, m_tot;

    pit_irq_ctrl #(.HOLDOFF(HOLDOFF), .OVF_WIDTH(4), .TOT_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .tick_in(tick_in), .enable(enable),
        .mask(mask), .ack(ack), .clear_ovf(clear_ovf), .irq_out(irq_out),
        .pending(pending), .queued(queued), .overrun_count(overrun_count),
        .overrun_sat(overrun_sat), .tick_total(tick_total)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit lost;
        lost = 1'b0;
        if (reset) begin
            m_pend = 0; m_q = 0; m_hold = 0; m_ovf = 0; m_tot = 0;
            return;
        end
        if (enable) begin
            if (tick_in) m_tot = (m_tot + 1) % TOT_MOD;
            if (m_hold > 0) begin
                if (tick_in && m_q) lost = 1'b1;
                if (m_hold == 1) begin
                    m_pend = m_q | tick_in;
                    m_q    = 0;
                end else if (tick_in) begin
                    m_q = 1;
                end
                m_hold = m_hold - 1;
            end else if (m_pend) begin
                if (ack) begin
                    m_pend = 0;
                    m_hold = HOLDOFF;
                    m_q    = tick_in;
                end else if (tick_in) begin
                    lost = 1'b1;
                end
            end else if (tick_in) begin
                m_pend = 1;
            end
        end else begin
            m_pend = 0; m_q = 0; m_hold = 0;
        end
        if (clear_ovf) m_ovf = lost ? 1 : 0;
        else if (lost && m_ovf < OVF_MAX) m_ovf = m_ovf + 1;
    endtask

    task automatic check_all();
        check_eq("pending", pending, m_pend);
        check_eq("irq_out", irq_out, m_pend & ~mask);
        check_eq("queued", queued, m_q);
        check_eq("overrun_count", overrun_count, m_ovf);
        check_eq("overrun_sat", overrun_sat, m_ovf == OVF_MAX);
        check_eq("tick_total", tick_total, m_tot);
    endtask

    task automatic step(input logic t, input logic a, input logic c);
        tick_in = t; ack = a; clear_ovf = c;
        @(posedge clk);
        model_step();
        #1;
        check_all();
        tick_in = 0; ack = 0; clear_ovf = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        step(0, 0, 0);
        reset = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0);
    endtask

    initial begin
        // Reset state
        do_reset();
        check_eq("rst_pending", pending, 0);
        check_eq("rst_irq", irq_out, 0);
        check_eq("rst_total", tick_total, 0);
        enable = 1;

        // Basic event, ack, hold-off, back to idle
        idle(3);
        step(1, 0, 0);
        check_eq("basic_irq", irq_out, 1);
        check_eq("basic_total", tick_total, 1);
        idle(3);
        step(0, 1, 0);
        check_eq("basic_ack_pending", pending, 0);
        idle(5);

        // Queue during hold-off
        step(1, 0, 0);
        step(0, 1, 0);
        step(0, 0, 0);
        step(1, 0, 0);
        check_eq("queue_set", queued, 1);
        idle(2);
        check_eq("queue_repend", pending, 1);
        check_eq("queue_cleared", queued, 0);
        check_eq("queue_no_ovf", overrun_count, 0);

        // Overrun while pending, then saturation
        do_reset();
        enable = 1;
        for (int i = 0; i < 3; i++) step(1, 0, 0);
        check_eq("ovr_two", overrun_count, 2);
        check_eq("ovr_total", tick_total, 3);
        for (int i = 0; i < 20; i++) step(1, 0, 0);
        check_eq("ovr_sat_count", overrun_count, 15);
        check_eq("ovr_sat_flag", overrun_sat, 1);

        // Clear coinciding with an overrun
        do_reset();
        enable = 1;
        for (int i = 0; i < 8; i++) step(1, 0, 0);
        check_eq("clr_pre", overrun_count, 7);
        step(1, 0, 1);
        check_eq("clr_with_ovr", overrun_count, 1);

        // Ack and tick together
        step(1, 1, 0);
        check_eq("acktick_queued", queued, 1);
        check_eq("acktick_ovf", overrun_count, 1);

        // Reset during hold-off with queued set
        step(0, 0, 0);
        do_reset();
        check_eq("rst_mid_queued", queued, 0);
        check_eq("rst_mid_ovf", overrun_count, 0);
        enable = 1;

        // Mask holds irq low; dropping it raises irq directly
        mask = 1;
        step(1, 0, 0);
        check_eq("mask_irq_low", irq_out, 0);
        mask = 0;
        #1;
        check_eq("unmask_irq", irq_out, 1);

        // Disable while pending, ticks ignored when disabled
        enable = 0;
        step(0, 0, 0);
        check_eq("dis_pending", pending, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0);
        check_eq("dis_total", tick_total, 1);
        enable = 1;

        // Total counter wrap
        do_reset();
        enable = 1;
        for (int i = 0; i < 256; i++) step(1, logic'($urandom_range(0, 1)), 0);
        check_eq("wrap_total", tick_total, 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            reset  = ($urandom_range(0, 199) == 0);
            enable = ($urandom_range(0, 15) != 0);
            mask   = ($urandom_range(0, 3) == 0);
            step(logic'($urandom_range(0, 2) == 0), logic'($urandom_range(0, 3) == 0),
                 logic'($urandom_range(0, 31) == 0));
        end
        reset = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/pit_irq_ctrl.md
Name: pit_irq_ctrl

Overview:
Interrupt collector that sits directly downstream of the mini PIT timer. It consumes the timer's single-cycle `interrupting` pulse and turns it into a level interrupt that a host can mask and acknowledge. A programmable hold-off window follows each acknowledge, with a one-deep queue, so back-to-back expiries are not lost. Overrun and total-event counters are provided for status readback on the status byte / uio pins.

Parameters:
- HOLDOFF, 4, number of cycles spent in HOLDOFF after an ack. 0 disables hold-off.
- OVF_WIDTH, 4, width of the saturating overrun counter.
- TOT_WIDTH, 8, width of the wrapping total-tick counter.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- tick_in  input  1  one-cycle expiry pulse from the timer.
- enable  input  1  collector enable. Low forces IDLE.
- mask  input  1  gates irq_out only. Pending state is unaffected.
- ack  input  1  host acknowledge, sampled each cycle.
- clear_ovf  input  1  clears the overrun counter.
- irq_out  output  1  level interrupt = pending & ~mask (combinational from registers).
- pending  output  1  high in state PENDING.
- queued  output  1  an event was captured during HOLDOFF.
- overrun_count  output  OVF_WIDTH  saturating count of lost events.
- overrun_sat  output  1  overrun_count == all ones.
- tick_total  output  TOT_WIDTH  wrapping count of ticks accepted while enabled.

Behaviour:
- **Reset:** state=IDLE, pending=0, queued=0, irq_out=0, overrun_count=0, overrun_sat=0, tick_total=0, holdoff counter=0.
- **Registers:** all state updates on posedge clk. Outputs are visible the cycle after the sampling edge, i.e. one-cycle latency from tick_in/ack.
- **enable=0:**
  - Next state is IDLE and queued is cleared.
  - Ticks are ignored and tick_total does not advance.
  - overrun_count is held, but clear_ovf still works.
- **enable=1, any state:** tick_in increments tick_total, wrapping from all ones to 0.
- **IDLE:**
  - tick -> PENDING.
  - ack is ignored.
- **PENDING:**
  - ack=0, tick=1 -> stay PENDING, overrun_count+1.
  - ack=1, HOLDOFF>0 -> HOLDOFF with the hold-off counter loaded to HOLDOFF-1. queued=tick_in (a same-cycle tick is queued, not counted as overrun).
  - ack=1, HOLDOFF=0 -> PENDING if tick_in, else IDLE. No overrun.
- **HOLDOFF:**
  - The counter decrements each cycle. The state lasts exactly HOLDOFF cycles.
  - tick while queued=0 -> queued=1.
  - tick while queued=1 -> overrun_count+1.
  - ack is ignored.
  - On the cycle the counter==0:
    - Next state is PENDING if (queued | tick_in), else IDLE. queued is cleared.
    - A tick on this final cycle while queued=1 counts as an overrun.
- **Overrun counter:**
  - Saturates at 2^OVF_WIDTH-1 and never wraps.
  - clear_ovf and an overrun increment in the same cycle -> overrun_count=1, so the event is not lost.
  - clear_ovf alone -> 0.
- **mask:**
  - mask=1 holds irq_out=0 while pending=1.
  - Deasserting mask with pending=1 raises irq_out with no further tick.
- **Reset mid-operation:** from any state, reset returns all outputs to their reset values on the next edge.
- **Unused encoding:** an unused state encoding recovers to IDLE.

Test Plan:
- **Basic event:** reset, enable=1, pulse tick_in at cycle 5 -> pending=1 and irq_out=1 from cycle 6, tick_total=1. Ack at cycle 10 -> pending=0 from cycle 11, state HOLDOFF for 4 cycles, then IDLE.
- **Queue during hold-off:** HOLDOFF=4, ack at cycle 10, tick at cycle 12 -> queued=1 at cycle 13. PENDING re-entered at cycle 15, queued=0, overrun_count=0.
- **Overrun while pending:** three ticks while pending with no ack -> overrun_count=2, pending=1, tick_total=3. Drive 20 extra ticks -> overrun_count=15 and overrun_sat=1, held, no wrap.
- **Same-cycle events:**
  - Ack and tick in the same cycle -> HOLDOFF with queued=1, overrun_count unchanged.
  - clear_ovf and an overrun tick in the same cycle with overrun_count=7 -> overrun_count=1.
- **Mask and enable:**
  - mask=1 and tick -> pending=1, irq_out=0. Drop mask -> irq_out=1 the same cycle.
  - enable=0 while pending -> IDLE next cycle. Ticks with enable=0 leave tick_total unchanged.
- **Reset and wrap:**
  - Reset asserted during HOLDOFF with queued=1 -> all outputs 0 next cycle.
  - 256 accepted ticks -> tick_total wraps to 0.
